// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter between the execution units' result requests and the
//   common data bus. Each cycle at most one requesting EXU is accepted. Its
//   result appears on the registered CDB outputs for exactly one cycle.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high
//   flush        discard this cycle's grant and suppress the next broadcast
//   exu_req      per-EXU result request
//   exu_rdy      per-EXU accept, combinational, one-hot or zero
//   exu_tag      per-EXU tag,       slice i = [i*TAG_W     +: TAG_W]
//   exu_wdata    per-EXU data,      slice i = [i*32        +: 32]
//   exu_inst_id  per-EXU ROB index, slice i = [i*ROB_PTR_W +: ROB_PTR_W]
//   cdb_wr       broadcast valid
//   cdb_tag      broadcast tag
//   cdb_wdata    broadcast data
//   cdb_inst_id  broadcast ROB index
module cdb_arbiter #(
  parameter int N_EXU     = 4,
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_EXU-1:0]           exu_req,
  output logic [N_EXU-1:0]           exu_rdy,
  input  logic [N_EXU*TAG_W-1:0]     exu_tag,
  input  logic [N_EXU*32-1:0]        exu_wdata,
  input  logic [N_EXU*ROB_PTR_W-1:0] exu_inst_id,
  output logic                       cdb_wr,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [31:0]                cdb_wdata,
  output logic [ROB_PTR_W-1:0]       cdb_inst_id
);

  localparam int PTR_W = (N_EXU > 1) ? $clog2(N_EXU) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_EXU - 1);

  logic [PTR_W-1:0]     ptr;

  logic                 hi_vld_p0;
  logic [PTR_W-1:0]     hi_idx_p0;
  logic                 lo_vld_p0;
  logic [PTR_W-1:0]     lo_idx_p0;
  logic                 vld_p0;
  logic [PTR_W-1:0]     grant_idx_p0;
  logic [PTR_W-1:0]     ptr_nxt_p0;
  logic [TAG_W-1:0]     tag_p0;
  logic [31:0]          wdata_p0;
  logic [ROB_PTR_W-1:0] inst_id_p0;

  logic                 vld_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic [31:0]          wdata_p1;
  logic [ROB_PTR_W-1:0] inst_id_p1;

  // ---- Stage p0: round-robin grant and winner payload select ----
  // The rotating search is split into two fixed-priority searches: the lowest
  // requester at or above ptr wins; otherwise the lowest requester below ptr
  // wins. Scanning downwards leaves the lowest match in each half.
  always_comb begin
    hi_vld_p0 = 1'b0;
    hi_idx_p0 = '0;
    lo_vld_p0 = 1'b0;
    lo_idx_p0 = '0;
    for (int i = N_EXU - 1; i >= 0; i--) begin
      if (exu_req[i]) begin
        if (PTR_W'(i) >= ptr) begin
          hi_vld_p0 = 1'b1;
          hi_idx_p0 = PTR_W'(i);
        end else begin
          lo_vld_p0 = 1'b1;
          lo_idx_p0 = PTR_W'(i);
        end
      end
    end
  end

  // Grant depends only on requests, ptr, flush and rst, never on payload.
  assign vld_p0       = (hi_vld_p0 | lo_vld_p0) & ~flush & ~rst;
  assign grant_idx_p0 = hi_vld_p0 ? hi_idx_p0 : lo_idx_p0;

  // Explicit wrap so a non-power-of-two N_EXU never lands on an unused index.
  assign ptr_nxt_p0 = (grant_idx_p0 == LAST_IDX) ? '0 : grant_idx_p0 + 1'b1;

  always_comb begin
    exu_rdy    = '0;
    tag_p0     = '0;
    wdata_p0   = '0;
    inst_id_p0 = '0;
    for (int i = 0; i < N_EXU; i++) begin
      if (grant_idx_p0 == PTR_W'(i)) begin
        exu_rdy[i] = vld_p0;
        tag_p0     = exu_tag[i*TAG_W +: TAG_W];
        wdata_p0   = exu_wdata[i*32 +: 32];
        inst_id_p0 = exu_inst_id[i*ROB_PTR_W +: ROB_PTR_W];
      end
    end
  end

  // ---- Stage p1: registered CDB broadcast ----
  // Payload holds when nothing is broadcast; consumers qualify with cdb_wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      vld_p1     <= 1'b0;
      tag_p1     <= '0;
      wdata_p1   <= '0;
      inst_id_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        ptr        <= ptr_nxt_p0;
        tag_p1     <= tag_p0;
        wdata_p1   <= wdata_p0;
        inst_id_p1 <= inst_id_p0;
      end
    end
  end

  assign cdb_wr      = vld_p1;
  assign cdb_tag     = tag_p1;
  assign cdb_wdata   = wdata_p1;
  assign cdb_inst_id = inst_id_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-EXU instance
  logic         rst4 = 1'b1, flush4 = 1'b0;
  logic [3:0]   req4 = '0, rdy4;
  logic [15:0]  tag4 = '0, id4 = '0;
  logic [127:0] data4 = '0;
  logic         wr4o;
  logic [3:0]   tag4o, id4o;
  logic [31:0]  data4o;

  // 3-EXU instance
  logic         rst3 = 1'b1, flush3 = 1'b0;
  logic [2:0]   req3 = '0, rdy3;
  logic [11:0]  tag3 = '0, id3 = '0;
  logic [95:0]  data3 = '0;
  logic         wr3o;
  logic [3:0]   tag3o, id3o;
  logic [31:0]  data3o;

  cdb_arbiter #(.N_EXU(4), .TAG_W(4), .ROB_DEPTH(16)) dut4 (
    .clk(clk), .rst(rst4), .flush(flush4), .exu_req(req4), .exu_rdy(rdy4),
    .exu_tag(tag4), .exu_wdata(data4), .exu_inst_id(id4),
    .cdb_wr(wr4o), .cdb_tag(tag4o), .cdb_wdata(data4o), .cdb_inst_id(id4o));

  cdb_arbiter #(.N_EXU(3), .TAG_W(4), .ROB_DEPTH(16)) dut3 (
    .clk(clk), .rst(rst3), .flush(flush3), .exu_req(req3), .exu_rdy(rdy3),
    .exu_tag(tag3), .exu_wdata(data3), .exu_inst_id(id3),
    .cdb_wr(wr3o), .cdb_tag(tag3o), .cdb_wdata(data3o), .cdb_inst_id(id3o));

  int checks = 0;
  int passes = 0;

  // Reference model for the 4-EXU instance
  int          m_ptr4 = 0;
  logic        m_wr4 = 1'b0;
  logic [3:0]  m_tag4 = '0, m_id4 = '0;
  logic [31:0] m_data4 = '0;
  logic [3:0]  exp_rdy4, got_rdy4;
  logic        got_wr4;
  logic [3:0]  got_tag4, got_id4;
  logic [31:0] got_data4;

  logic [2:0]  got_rdy3;
  logic        got_wr3;
  logic [3:0]  got_id3;

  // First requester found when walking ptr, ptr+1, ... modulo n; -1 if none.
  function automatic int pick(input int n, input int ptr, input logic [7:0] req);
    for (int k = 0; k < n; k++) begin
      if (req[(ptr + k) % n]) return (ptr + k) % n;
    end
    return -1;
  endfunction

  // One clock of the 4-EXU instance: sample rdy mid-cycle, advance the model
  // at the edge, sample the CDB just after the edge.
  task automatic step4();
    int g;
    @(negedge clk);
    got_rdy4 = rdy4;
    g = (rst4 || flush4) ? -1 : pick(4, m_ptr4, {4'b0, req4});
    exp_rdy4 = (g >= 0) ? 4'(1 << g) : 4'b0;
    @(posedge clk);
    if (rst4) begin
      m_ptr4 = 0; m_wr4 = 1'b0; m_tag4 = '0; m_data4 = '0; m_id4 = '0;
    end else if (g >= 0) begin
      m_wr4 = 1'b1;
      m_tag4 = tag4[g*4 +: 4];
      m_data4 = data4[g*32 +: 32];
      m_id4 = id4[g*4 +: 4];
      m_ptr4 = (g + 1) % 4;
    end else begin
      m_wr4 = 1'b0;
    end
    #1;
    got_wr4 = wr4o; got_tag4 = tag4o; got_data4 = data4o; got_id4 = id4o;
  endtask

  task automatic step3();
    @(negedge clk);
    got_rdy3 = rdy3;
    @(posedge clk);
    #1;
    got_wr3 = wr3o; got_id3 = id3o;
  endtask

  task automatic test_reset();
    rst4 = 1'b1; flush4 = 1'b1; req4 = 4'hF; tag4 = '1; data4 = '1; id4 = '1;
    step4();
    checks++; if (got_rdy4 !== 4'b0) $display("FAIL reset_rdy got %b exp 0000", got_rdy4); else passes++;
    checks++; if (got_wr4 !== 1'b0) $display("FAIL reset_wr got %b exp 0", got_wr4); else passes++;
    checks++; if (got_tag4 !== 4'h0) $display("FAIL reset_tag got %h exp 0", got_tag4); else passes++;
    checks++; if (got_data4 !== 32'h0) $display("FAIL reset_data got %h exp 0", got_data4); else passes++;
    checks++; if (got_id4 !== 4'h0) $display("FAIL reset_id got %h exp 0", got_id4); else passes++;
    rst4 = 1'b0; flush4 = 1'b0; req4 = '0; tag4 = '0; data4 = '0; id4 = '0;
    step4();
    checks++; if (got_wr4 !== 1'b0) $display("FAIL idle_wr got %b exp 0", got_wr4); else passes++;
  endtask

  task automatic test_single();
    tag4[11:8] = 4'd3; data4[95:64] = 32'hDEADBEEF; id4[11:8] = 4'd5; req4 = 4'b0100;
    step4();
    checks++; if (got_rdy4 !== 4'b0100) $display("FAIL single_rdy got %b exp 0100", got_rdy4); else passes++;
    checks++; if (got_wr4 !== 1'b1) $display("FAIL single_wr got %b exp 1", got_wr4); else passes++;
    checks++; if (got_tag4 !== 4'd3) $display("FAIL single_tag got %h exp 3", got_tag4); else passes++;
    checks++; if (got_data4 !== 32'hDEADBEEF) $display("FAIL single_data got %h exp deadbeef", got_data4); else passes++;
    checks++; if (got_id4 !== 4'd5) $display("FAIL single_id got %h exp 5", got_id4); else passes++;
    req4 = 4'b0;
    step4();
    checks++; if (got_wr4 !== 1'b0) $display("FAIL single_wr_drop got %b exp 0", got_wr4); else passes++;
    checks++; if (got_tag4 !== 4'd3) $display("FAIL single_tag_hold got %h exp 3", got_tag4); else passes++;
    req4 = 4'hF;
    step4();
    checks++; if (got_rdy4 !== 4'b1000) $display("FAIL single_ptr3 got %b exp 1000", got_rdy4); else passes++;
    req4 = 4'b0;
    step4();
  endtask

  task automatic test_all_continuous();
    rst4 = 1'b1;
    step4();
    rst4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id4[i*4 +: 4] = 4'(i); tag4[i*4 +: 4] = 4'(i + 8); data4[i*32 +: 32] = 32'h1000 + i;
    end
    req4 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      step4();
      checks++; if (got_rdy4 !== 4'(1 << (k % 4))) $display("FAIL rr_rdy[%0d] got %b exp %b", k, got_rdy4, 4'(1 << (k % 4))); else passes++;
      checks++; if (got_wr4 !== 1'b1) $display("FAIL rr_wr[%0d] got %b exp 1", k, got_wr4); else passes++;
      checks++; if (got_id4 !== 4'(k % 4)) $display("FAIL rr_id[%0d] got %h exp %h", k, got_id4, 4'(k % 4)); else passes++;
    end
    req4 = 4'b0;
    step4();
  endtask

  task automatic test_hold();
    req4 = 4'b0001;
    step4();
    checks++; if (got_rdy4 !== 4'b0001) $display("FAIL hold_pre got %b exp 0001", got_rdy4); else passes++;
    id4[3:0] = 4'd7; data4[31:0] = 32'hA0A0A0A0;
    id4[7:4] = 4'd9; data4[63:32] = 32'hB1B1B1B1;
    req4 = 4'b0011;
    step4();
    checks++; if (got_rdy4 !== 4'b0010) $display("FAIL hold_rdy1 got %b exp 0010", got_rdy4); else passes++;
    checks++; if (got_id4 !== 4'd9) $display("FAIL hold_id1 got %h exp 9", got_id4); else passes++;
    checks++; if (got_data4 !== 32'hB1B1B1B1) $display("FAIL hold_data1 got %h exp b1b1b1b1", got_data4); else passes++;
    req4 = 4'b0001;
    step4();
    checks++; if (got_rdy4 !== 4'b0001) $display("FAIL hold_rdy0 got %b exp 0001", got_rdy4); else passes++;
    checks++; if (got_wr4 !== 1'b1) $display("FAIL hold_wr0 got %b exp 1", got_wr4); else passes++;
    checks++; if (got_id4 !== 4'd7) $display("FAIL hold_id0 got %h exp 7", got_id4); else passes++;
    checks++; if (got_data4 !== 32'hA0A0A0A0) $display("FAIL hold_data0 got %h exp a0a0a0a0", got_data4); else passes++;
    req4 = 4'b0;
    step4();
  endtask

  task automatic test_flush();
    // ptr is 1 here; a grant just before the flush must stay visible
    req4 = 4'b0001;
    step4();
    checks++; if (got_wr4 !== 1'b1) $display("FAIL flush_prev_wr got %b exp 1", got_wr4); else passes++;
    id4[11:8] = 4'hC; req4 = 4'b0100; flush4 = 1'b1;
    @(negedge clk);
    checks++; if (wr4o !== 1'b1) $display("FAIL flush_visible_wr got %b exp 1", wr4o); else passes++;
    step4();
    checks++; if (got_rdy4 !== 4'b0) $display("FAIL flush_rdy got %b exp 0000", got_rdy4); else passes++;
    checks++; if (got_wr4 !== 1'b0) $display("FAIL flush_wr got %b exp 0", got_wr4); else passes++;
    flush4 = 1'b0;
    step4();
    checks++; if (got_rdy4 !== 4'b0100) $display("FAIL flush_after_rdy got %b exp 0100", got_rdy4); else passes++;
    checks++; if (got_id4 !== 4'hC) $display("FAIL flush_after_id got %h exp c", got_id4); else passes++;
    req4 = 4'hF;
    step4();
    checks++; if (got_rdy4 !== 4'b1000) $display("FAIL flush_ptr got %b exp 1000", got_rdy4); else passes++;
    req4 = 4'b0;
    step4();
  endtask

  task automatic test_reset_mid();
    req4 = 4'hF; rst4 = 1'b1;
    step4();
    checks++; if (got_rdy4 !== 4'b0) $display("FAIL rstmid_rdy got %b exp 0000", got_rdy4); else passes++;
    checks++; if (got_wr4 !== 1'b0) $display("FAIL rstmid_wr got %b exp 0", got_wr4); else passes++;
    checks++; if ({got_tag4, got_data4, got_id4} !== 40'h0) $display("FAIL rstmid_fields got %h exp 0", {got_tag4, got_data4, got_id4}); else passes++;
    rst4 = 1'b0;
    step4();
    checks++; if (got_rdy4 !== 4'b0001) $display("FAIL rstmid_ptr got %b exp 0001", got_rdy4); else passes++;
    req4 = 4'b0;
    step4();
  endtask

  task automatic test_random();
    logic [3:0] pend;
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          tag4[i*4 +: 4] = 4'($urandom);
          data4[i*32 +: 32] = $urandom;
          id4[i*4 +: 4] = 4'($urandom);
        end
      end
      req4 = pend;
      flush4 = ($urandom_range(0, 9) == 0);
      step4();
      checks++; if (got_rdy4 !== exp_rdy4) $display("FAIL rnd_rdy[%0d] got %b exp %b", c, got_rdy4, exp_rdy4); else passes++;
      checks++; if (got_wr4 !== m_wr4) $display("FAIL rnd_wr[%0d] got %b exp %b", c, got_wr4, m_wr4); else passes++;
      checks++; if ({got_tag4, got_data4, got_id4} !== {m_tag4, m_data4, m_id4})
        $display("FAIL rnd_payload[%0d] got %h exp %h", c, {got_tag4, got_data4, got_id4}, {m_tag4, m_data4, m_id4});
      else passes++;
      pend = pend & ~exp_rdy4;
    end
    flush4 = 1'b0; req4 = '0;
    step4();
  endtask

  task automatic test_wrap3();
    rst3 = 1'b1;
    step3();
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) id3[i*4 +: 4] = 4'(i + 1);
    req3 = 3'b100;
    step3();
    checks++; if (got_rdy3 !== 3'b100) $display("FAIL wrap_first got %b exp 100", got_rdy3); else passes++;
    req3 = 3'b111;
    for (int k = 0; k < 6; k++) begin
      step3();
      checks++; if (got_rdy3 !== 3'(1 << (k % 3))) $display("FAIL wrap_rdy[%0d] got %b exp %b", k, got_rdy3, 3'(1 << (k % 3))); else passes++;
      checks++; if (got_wr3 !== 1'b1 || got_id3 !== 4'(k % 3 + 1)) $display("FAIL wrap_cdb[%0d] got %b/%h exp 1/%h", k, got_wr3, got_id3, 4'(k % 3 + 1)); else passes++;
    end
    req3 = '0;
    step3();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_continuous();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    test_wrap3();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
